// File: rtl/divider_pkg.sv
// Shared definitions for the divider arbiter slice.
//   DIV_WIDTH       : operand/result width of the shared divider
//   CNT_W           : latency counter width (covers DIV_LATENCY up to 63)
//   DIV_ZERO_RESULT : result reported for a zero divisor when the
//                     DIV_ZERO_CHECK_EN build option is enabled
//   div_state_e     : arbiter FSM states
//   div_ops_t       : one requester's operand pair
package divider_pkg;

  localparam int DIV_WIDTH = 48;
  localparam int CNT_W     = 6;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_RESULT = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
  } div_ops_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : index holding highest priority this cycle
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted requester
//   any_o : at least one request present
module rr_arbiter
  import divider_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  // Walk the ring starting at ptr_i; the first requester found wins.
  always_comb begin
    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum  = {1'b0, ptr_i} + (PTR_W+1)'(k);
      cand = (sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                          : sum[PTR_W-1:0];
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/divider_arbiter.sv
// Shares one multi-cycle 48-bit divider among NUM_REQ requesters.
// Build option: define DIV_ZERO_CHECK_EN to short-circuit zero divisors
// (adds op_divZero port).
//   clk, rst_n          : clock, async active-low reset
//   in_req              : per-requester request level
//   in_dividend/divider : per-requester operands, 48-bit slices
//   op_grant            : one-hot pulse in the cycle operands are captured
//   op_dividerIn1/In2   : latched operands driven to the divider
//   in_outputOfDivider  : divider result
//   op_result           : captured quotient, shared
//   op_resultValid      : one-hot pulse to the owning requester
//   op_busy             : operation in flight (BUSY or DONE)
//   op_divZero          : (option) zero-divisor flag, pulses with valid
module divider_arbiter
  import divider_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           in_req,
  input  logic [NUM_REQ*DIV_WIDTH-1:0] in_dividend,
  input  logic [NUM_REQ*DIV_WIDTH-1:0] in_divider,
  output logic [NUM_REQ-1:0]           op_grant,
  output logic [DIV_WIDTH-1:0]         op_dividerIn1,
  output logic [DIV_WIDTH-1:0]         op_dividerIn2,
  input  logic [DIV_WIDTH-1:0]         in_outputOfDivider,
  output logic [DIV_WIDTH-1:0]         op_result,
  output logic [NUM_REQ-1:0]           op_resultValid,
`ifdef DIV_ZERO_CHECK_EN
  output logic                         op_divZero,
`endif
  output logic                         op_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  div_state_e               state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [PTR_W-1:0]         ptr_q;
  logic [PTR_W-1:0]         owner_q;
  logic [DIV_WIDTH-1:0]     in1_q, in2_q, result_q;
  logic [NUM_REQ-1:0]       valid_q;
`ifdef DIV_ZERO_CHECK_EN
  logic                     divzero_q;
`endif

  div_ops_t [NUM_REQ-1:0]   ops;
  div_ops_t                 sel;
  logic [NUM_REQ-1:0]       gnt_oh;
  logic [PTR_W-1:0]         gnt_idx;
  logic [PTR_W-1:0]         ptr_nxt;
  logic                     any_req;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign ops[g].dividend = in_dividend[g*DIV_WIDTH +: DIV_WIDTH];
    assign ops[g].divisor  = in_divider[g*DIV_WIDTH +: DIV_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (in_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .any_o (any_req)
  );

  assign sel     = ops[gnt_idx];
  assign ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);

  // The grant marks the edge that captures operands, so it is shown
  // during the IDLE cycle itself; reset masks it so nothing leaks out
  // while rst_n is low.
  assign op_grant       = (rst_n && state_q == IDLE) ? gnt_oh : '0;
  assign op_busy        = (state_q != IDLE);
  assign op_dividerIn1  = in1_q;
  assign op_dividerIn2  = in2_q;
  assign op_result      = result_q;
  assign op_resultValid = valid_q;
`ifdef DIV_ZERO_CHECK_EN
  assign op_divZero     = divzero_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      result_q  <= '0;
      valid_q   <= '0;
`ifdef DIV_ZERO_CHECK_EN
      divzero_q <= 1'b0;
`endif
    end else begin
      valid_q   <= '0;
`ifdef DIV_ZERO_CHECK_EN
      divzero_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= gnt_idx;
            ptr_q   <= ptr_nxt;
`ifdef DIV_ZERO_CHECK_EN
            // Zero divisor never reaches the divider; its inputs keep
            // the previous operands.
            if (sel.divisor == '0) begin
              result_q  <= DIV_ZERO_RESULT;
              valid_q   <= gnt_oh;
              divzero_q <= 1'b1;
              state_q   <= DONE;
            end else
`endif
            begin
              in1_q   <= sel.dividend;
              in2_q   <= sel.divisor;
              cnt_q   <= CNT_W'(DIV_LATENCY);
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          // Last BUSY cycle: divider output has had DIV_LATENCY cycles.
          if (cnt_q == CNT_W'(1)) begin
            result_q <= in_outputOfDivider;
            cnt_q    <= '0;
            valid_q  <= NUM_REQ'(1) << owner_q;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Randomized scoreboard bench for divider_arbiter (NUM_REQ=4, DIV_LATENCY=8).
module tb_divider_arbiter;

  localparam int N = 4;
  localparam int L = 8;
  localparam int W = 48;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        in_req;
  logic [N-1:0][W-1:0] dvd, dvs;
  logic [N-1:0]        op_grant, op_resultValid;
  logic [W-1:0]        op_dividerIn1, op_dividerIn2, div_out, op_result;
  logic                op_busy;
`ifdef DIV_ZERO_CHECK_EN
  logic                op_divZero;
`endif

  always #5 clk = ~clk;

  divider_arbiter #(.NUM_REQ(N), .DIV_LATENCY(L)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_req             (in_req),
    .in_dividend        (dvd),
    .in_divider         (dvs),
    .op_grant           (op_grant),
    .op_dividerIn1      (op_dividerIn1),
    .op_dividerIn2      (op_dividerIn2),
    .in_outputOfDivider (div_out),
    .op_result          (op_result),
    .op_resultValid     (op_resultValid),
`ifdef DIV_ZERO_CHECK_EN
    .op_divZero         (op_divZero),
`endif
    .op_busy            (op_busy)
  );

  function automatic logic [W-1:0] qdiv(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction

  // Divider model: the quotient only appears once the operands have been
  // steady for L cycles; before that it shows garbage.
  int       stab = 0;
  logic [W-1:0] p1 = '0, p2 = '0;
  always @(negedge clk) begin
    if (op_dividerIn1 != p1 || op_dividerIn2 != p2) stab <= 0;
    else stab <= stab + 1;
    p1 <= op_dividerIn1;
    p2 <= op_dividerIn2;
  end
  assign div_out = (stab >= L-1) ? qdiv(op_dividerIn1, op_dividerIn2) : 48'h0BAD_0BAD_0BAD;

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int       idx;
    logic [W-1:0] res;
    int       due;
    bit       dz;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, m_ptr = 0, free_at = 0, busy_lo = 1, busy_hi = 0;
  logic [W-1:0] m_in1 = '0, m_in2 = '0, last_res = '0;
  int   gcnt[N], vcnt[N];
  int   tmo_cnt = 0, tmo_seen = 0;
  bit   final_chk = 1'b0;
  exp_t e;
  int   w;
  logic [N-1:0] exp_g;
  logic [W-1:0] a, b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p+k)%N]) return (p+k)%N;
    return -1;
  endfunction

  initial for (int i = 0; i < N; i++) begin gcnt[i] = 0; vcnt[i] = 0; end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_grant",  64'(op_grant), 64'd0);
      chk("rst_valid",  64'(op_resultValid), 64'd0);
      chk("rst_busy",   64'(op_busy), 64'd0);
      chk("rst_in1",    64'(op_dividerIn1), 64'd0);
      chk("rst_in2",    64'(op_dividerIn2), 64'd0);
      chk("rst_result", 64'(op_result), 64'd0);
      q.delete();
      m_ptr = 0; free_at = 0; busy_lo = 1; busy_hi = 0;
      m_in1 = '0; m_in2 = '0; last_res = '0;
    end else begin
      cyc++;
      chk("div_in1", 64'(op_dividerIn1), 64'(m_in1));
      chk("div_in2", 64'(op_dividerIn2), 64'(m_in2));
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        last_res = e.res;
        chk("valid", 64'(op_resultValid), 64'(1) << e.idx);
`ifdef DIV_ZERO_CHECK_EN
        chk("divzero", 64'(op_divZero), 64'(e.dz));
`endif
        vcnt[e.idx]++;
      end else begin
        chk("stray_valid", 64'(op_resultValid), 64'd0);
`ifdef DIV_ZERO_CHECK_EN
        chk("stray_divzero", 64'(op_divZero), 64'd0);
`endif
      end
      chk("result", 64'(op_result), 64'(last_res));
      chk("busy", 64'(op_busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      exp_g = '0;
      w = -1;
      if (cyc >= free_at && in_req != '0) begin
        w = pick(in_req, m_ptr);
        exp_g[w] = 1'b1;
      end
      chk("grant", 64'(op_grant), 64'(exp_g));
      if (w >= 0) begin
        a = dvd[w];
        b = dvs[w];
        e.idx = w;
        busy_lo = cyc + 1;
`ifdef DIV_ZERO_CHECK_EN
        if (b == '0) begin
          e.res = '1; e.due = cyc + 1; e.dz = 1'b1;
          free_at = cyc + 2; busy_hi = cyc + 1;
        end else
`endif
        begin
          e.res = qdiv(a, b); e.due = cyc + L + 1; e.dz = 1'b0;
          free_at = cyc + L + 2; busy_hi = cyc + L + 1;
          m_in1 = a; m_in2 = b;
        end
        q.push_back(e);
        m_ptr = (w + 1) % N;
        gcnt[w]++;
      end
    end
    chk("timeout", 64'(tmo_cnt), 64'(tmo_seen));
    tmo_seen = tmo_cnt;
    if (final_chk) chk("drain", 64'(q.size()), 64'd0);
  end

  // ---------------- stimulus ----------------
  int st[N], gack[N], vack[N];

  function automatic logic [W-1:0] rnd_dvd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_dvs(input int pz);
    logic [63:0] t;
    if (int'($urandom_range(99, 0)) < pz) return '0;
    if ($urandom_range(1, 0) == 0) return W'($urandom_range(1000, 1));
    t = {$urandom(), $urandom()};
    t = t >> $urandom_range(63, 16);
    return (t[W-1:0] == '0) ? W'(1) : t[W-1:0];
  endfunction

  task automatic raise(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    dvd[i] = x; dvs[i] = y; in_req[i] = 1'b1; st[i] = 1;
  endtask

  task automatic drive(input int p_req, input int p_scr, input int p_drop, input int p_zero);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (gcnt[i] != gack[i]) begin gack[i] = gcnt[i]; st[i] = 2; end
      if (vcnt[i] != vack[i]) begin vack[i] = vcnt[i]; st[i] = 0; in_req[i] = 1'b0; end
      if (st[i] == 0 && int'($urandom_range(99, 0)) < p_req)
        raise(i, rnd_dvd(), rnd_dvs(p_zero));
      else if (st[i] == 2) begin
        if (int'($urandom_range(99, 0)) < p_scr) begin dvd[i] = rnd_dvd(); dvs[i] = rnd_dvs(0); end
        if (int'($urandom_range(99, 0)) < p_drop) in_req[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_grant(input int i);
    int g0 = gcnt[i];
    int n  = 0;
    while (gcnt[i] == g0 && n < 200) begin drive(0, 0, 0, 0); n++; end
    if (gcnt[i] == g0) tmo_cnt++;
  endtask

  task automatic wait_valid(input int i);
    int v0 = vcnt[i];
    int n  = 0;
    while (vcnt[i] == v0 && n < 200) begin drive(0, 0, 0, 0); n++; end
    if (vcnt[i] == v0) tmo_cnt++;
  endtask

  task automatic clear_drv();
    for (int i = 0; i < N; i++) begin
      in_req[i] = 1'b0; st[i] = 0; gack[i] = gcnt[i]; vack[i] = vcnt[i];
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_req = '0;
    dvd = '0;
    dvs = '0;
    for (int i = 0; i < N; i++) begin st[i] = 0; gack[i] = 0; vack[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single requester, 100 / 7
    raise(0, 48'd100, 48'd7);
    wait_valid(0);

    // everyone requesting back to back
    repeat (80) drive(100, 0, 0, 0);

    // randomized traffic: operand churn and dropped requests while owned
    repeat (1500) drive(30, 25, 10, 10);
    repeat (60) drive(0, 0, 0, 0);

    // explicit zero divisor
    raise(3, 48'd12345, 48'd0);
    wait_valid(3);

    // reset in the middle of an operation
    raise(2, 48'd5000, 48'd3);
    wait_grant(2);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    clear_drv();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) raise(i, rnd_dvd(), rnd_dvs(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (80) drive(0, 0, 0, 0);

    repeat (500) drive(30, 20, 10, 15);
    repeat (60) drive(0, 0, 0, 0);

    final_chk = 1'b1;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the single 48-bit divider (2..8).
REQ-002 Parameter DIV_LATENCY, default 8, cycles from stable divider operands to valid divider result (1..63).
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_req  input  NUM_REQ  per-requester request level, held with operands until that requester's op_resultValid.
REQ-006 Port in_dividend  input  NUM_REQ*48  per-requester dividend, slice i = bits [48*i+47:48*i].
REQ-007 Port in_divider  input  NUM_REQ*48  per-requester divisor, same slicing.
REQ-008 Port op_grant  output  NUM_REQ  one-hot, one-cycle pulse marking operand capture.
REQ-009 Port op_dividerIn1  output  48  latched dividend to divider.
REQ-010 Port op_dividerIn2  output  48  latched divisor to divider.
REQ-011 Port in_outputOfDivider  input  48  divider result.
REQ-012 Port op_result  output  48  captured quotient, shared by all requesters.
REQ-013 Port op_resultValid  output  NUM_REQ  one-hot, one-cycle pulse to owning requester.
REQ-014 Port op_busy  output  1  high in BUSY and DONE states.

Function
REQ-015 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-016 IDLE with any in_req bit high: round-robin pick i, pulse op_grant[i], latch slice i operands, load counter with DIV_LATENCY, next state BUSY.
REQ-017 Round-robin: after grant to i, priority starts at (i+1) mod NUM_REQ; pointer reset value 0.
REQ-018 BUSY: op_dividerIn1/In2 hold latched operands unchanged; counter decrements each cycle; when counter equals 1, in_outputOfDivider is captured into op_result and next state is DONE.
REQ-019 Latency: grant in cycle T gives BUSY for T+1..T+DIV_LATENCY and op_resultValid[i] in cycle T+DIV_LATENCY+1.
REQ-020 DONE: pulse op_resultValid[owner] for one cycle, next state IDLE; earliest next grant is the following cycle (DIV_LATENCY+2 cycles per operation).
REQ-021 in_req changes and new requests during BUSY/DONE are ignored; operation completes and pulses valid even if owner dropped in_req.
REQ-022 op_result holds its last captured value until the next capture.
REQ-023 op_grant and op_resultValid are zero in every cycle other than those in REQ-016/REQ-020.

Reset
REQ-024 rst_n low, including mid-operation: state IDLE, counter 0, RR pointer 0, op_grant, op_resultValid, op_busy, op_dividerIn1, op_dividerIn2, op_result all zero; in-flight operation discarded with no valid pulse.
REQ-025 First grant occurs no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro DIV_ZERO_CHECK_EN defined: port op_divZero (output, 1) exists; a granted zero divisor skips BUSY, goes IDLE->DONE, op_result = 48'hFFFF_FFFF_FFFF, op_divZero pulses with op_resultValid (latency 1 cycle after grant), divider inputs are not updated.
REQ-027 Macro undefined: no op_divZero port; zero divisors pass through the divider with normal DIV_LATENCY timing.

Structure
REQ-028 Shared package divider_pkg holds DIV_WIDTH=48, the FSM state enum and DIV_ZERO_RESULT constant.
REQ-029 Round-robin selection is a sub-module rr_arbiter (request vector + pointer in, one-hot grant out, combinational).

Verification
REQ-030 Single req: in_req=4'b0001, dividend 100, divisor 7, divider model returns 14 after 8 cycles -> grant[0] at T, resultValid[0] at T+9, op_result=14.
REQ-031 All four requesting continuously -> grants in order 0,1,2,3,0 each spaced 10 cycles, each result routed to correct valid bit.
REQ-032 Requester 2 changes its operands during BUSY -> op_dividerIn1/In2 unchanged, result reflects operands at grant.
REQ-033 rst_n pulsed low at T+4 of an operation -> all outputs 0 immediately, no resultValid, next grant to requester 0 after release.
REQ-034 DIV_ZERO_CHECK_EN defined, divisor 0 -> resultValid and op_divZero at T+1, op_result all ones; undefined -> normal 9-cycle path.
REQ-035 Owner drops in_req at T+3 -> resultValid still pulses at T+9, next grant follows RR order.
